// File: rtl/mips_boot_loader.sv
// Byte-serial program loader for pipe_MIPS32: parses a framed, checksummed image,
// writes it word-by-word into instruction memory, then releases the core at the frame base.
module mips_boot_loader #(
    parameter int          AW        = 10,   // 9..16: base address is assembled from two bytes
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          core_hold_o,
    output logic          core_start_o,
    output logic [31:0]   core_pc_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [3:0] {
        S_SYNC, S_CNT_HI, S_CNT_LO, S_ADR_HI, S_ADR_LO,
        S_DATA, S_CSUM, S_START, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;       // words still to receive
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   nxt_q, nxt_d;       // address of the word being assembled
    logic [1:0]      bidx_q, bidx_d;
    logic [23:0]     asm_q, asm_d;
    logic [7:0]      csum_q, csum_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            hold_q, hold_d;
    logic [31:0]     pc_q, pc_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            accept;

    assign accept = in_valid_i && (state_q != S_START);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        nxt_d   = nxt_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        pc_d    = pc_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_SYNC, S_ERROR: begin
                if (accept && in_data_i == SYNC_BYTE) begin
                    state_d = S_CNT_HI;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    csum_d  = 8'd0;
                    bidx_d  = 2'd0;
                    asm_d   = 24'd0;
                end
            end
            S_CNT_HI: if (accept) begin
                cnt_d[15:8] = in_data_i;
                csum_d      = csum_q + in_data_i;
                state_d     = S_CNT_LO;
            end
            S_CNT_LO: if (accept) begin
                cnt_d[7:0] = in_data_i;
                csum_d     = csum_q + in_data_i;
                state_d    = S_ADR_HI;
            end
            S_ADR_HI: if (accept) begin
                base_d  = AW'({in_data_i, 8'h00});
                csum_d  = csum_q + in_data_i;
                state_d = S_ADR_LO;
            end
            S_ADR_LO: if (accept) begin
                base_d  = {base_q[AW-1:8], in_data_i};
                nxt_d   = {base_q[AW-1:8], in_data_i};
                csum_d  = csum_q + in_data_i;
                state_d = (cnt_q == 16'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: if (accept) begin
                csum_d = csum_q + in_data_i;
                if (bidx_q == 2'd3) begin
                    we_d    = 1'b1;
                    wdata_d = {asm_q, in_data_i};
                    addr_d  = nxt_q;
                    nxt_d   = nxt_q + AW'(1);   // wraps modulo 2^AW by width
                    bidx_d  = 2'd0;
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = S_CSUM;
                end else begin
                    asm_d  = {asm_q[15:0], in_data_i};
                    bidx_d = bidx_q + 2'd1;
                end
            end
            S_CSUM: if (accept) begin
                if (in_data_i == csum_q) begin
                    state_d = S_START;
                    hold_d  = 1'b0;
                    done_d  = 1'b1;
                    pc_d    = {{(32-AW){1'b0}}, base_q};
                end else begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end
            end
            S_START: state_d = S_SYNC;
            default: state_d = S_SYNC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register is reset so a
    // mid-frame reset leaves no partial word or count behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_SYNC;
            cnt_q   <= 16'd0;
            base_q  <= '0;
            nxt_q   <= '0;
            bidx_q  <= 2'd0;
            asm_q   <= 24'd0;
            csum_q  <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            hold_q  <= 1'b1;
            pc_q    <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            nxt_q   <= nxt_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o   = (state_q != S_START);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_hold_o  = hold_q;
    assign core_start_o = (state_q == S_START);
    assign core_pc_o    = pc_q;
    assign busy_o       = (state_q != S_SYNC) && (state_q != S_ERROR);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: frames are driven byte by byte while a scoreboard
// of expected memory writes and start PCs is checked against the DUT outputs.
module tb_mips_boot_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          core_start;
    logic [31:0]   core_pc;
    logic          busy;
    logic          done;
    logic          err;

    mips_boot_loader #(.AW(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .core_hold_o  (core_hold),
        .core_start_o (core_start),
        .core_pc_o    (core_pc),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t          exp_wr[$];
    logic [31:0]  exp_pc[$];
    logic [31:0]  words[$];
    int           compared   = 0;
    int           mismatched = 0;
    bit           gaps       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; in_ready is stable until the next edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int budget;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        forever begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            budget++;
            if (budget > 10) begin
                check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        check("spurious_we", {31'd0, mem_we}, 32'd0);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", {22'd0, mem_addr}, {22'd0, w.addr});
                        check("wr_data", mem_wdata, w.data);
                    end
                end
                if (core_start) begin
                    if (exp_pc.size() == 0) begin
                        check("spurious_start", {31'd0, core_start}, 32'd0);
                    end else begin
                        check("start_pc", core_pc, exp_pc.pop_front());
                        check("start_hold", {31'd0, core_hold}, 32'd0);
                        check("start_done", {31'd0, done}, 32'd1);
                        check("start_ready", {31'd0, in_ready}, 32'd0);
                    end
                end
            end
        end
    endtask

    // Sends a frame built from words[]; only the first max_bytes bytes are driven.
    task automatic send_frame(input logic [15:0] n, input logic [15:0] base,
                              input logic [7:0] flip, input int max_bytes);
        logic [7:0] b[$];
        logic [7:0] sum;
        wr_t        w;
        b = {8'hA5, n[15:8], n[7:0], base[15:8], base[7:0]};
        for (int k = 0; k < int'(n); k++) begin
            b.push_back(words[k][31:24]);
            b.push_back(words[k][23:16]);
            b.push_back(words[k][15:8]);
            b.push_back(words[k][7:0]);
        end
        sum = 8'd0;
        for (int i = 1; i < b.size(); i++) sum = sum + b[i];
        b.push_back(sum ^ flip);
        for (int k = 0; k < int'(n); k++) begin
            if (8 + 4 * k < max_bytes) begin
                w.addr = AW'(base[AW-1:0] + AW'(k));
                w.data = words[k];
                exp_wr.push_back(w);
            end
        end
        if (flip == 8'd0 && max_bytes >= b.size())
            exp_pc.push_back({{(32-AW){1'b0}}, base[AW-1:0]});
        for (int i = 0; i < b.size() && i < max_bytes; i++) begin
            send_byte(b[i]);
            if (i == 0) begin
                check("sync_busy", {31'd0, busy}, 32'd1);
                check("sync_hold", {31'd0, core_hold}, 32'd1);
                check("sync_err_clr", {31'd0, err}, 32'd0);
                check("sync_done_clr", {31'd0, done}, 32'd0);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"},  {22'd0, mem_addr}, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_hold"},  {31'd0, core_hold}, 32'd1);
        check({tag, "_start"}, {31'd0, core_start}, 32'd0);
        check({tag, "_pc"},    core_pc, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_err"},   {31'd0, err}, 32'd0);
    endtask

    task automatic check_status(input string tag, input bit d, input bit e, input bit h);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_err"},  {31'd0, err},  {31'd0, e});
        check({tag, "_hold"}, {31'd0, core_hold}, {31'd0, h});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: program image at base 0, good checksum
        words = {32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                 32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        send_frame(16'd8, 16'h0000, 8'h00, 1000);
        check_status("t1", 1'b1, 1'b0, 1'b0);

        // 2: same image, corrupted checksum, then a good one
        send_frame(16'd8, 16'h0000, 8'h01, 1000);
        check_status("t2_bad", 1'b0, 1'b1, 1'b1);
        send_byte(8'h33);   // discarded in ERROR
        check("t2_err_discard", {31'd0, err}, 32'd1);
        send_frame(16'd8, 16'h0000, 8'h00, 1000);
        check_status("t2_good", 1'b1, 1'b0, 1'b0);

        // 3: empty frame only moves the start PC
        send_frame(16'd0, 16'h0078, 8'h00, 1000);
        check_status("t3", 1'b1, 1'b0, 1'b0);

        // 4: address wrap past the top of memory
        words = {32'hdeadbeef, 32'h0badf00d};
        send_frame(16'd2, 16'h03FF, 8'h00, 1000);
        check_status("t4", 1'b1, 1'b0, 1'b0);

        // 5: junk before sync and random valid gaps
        words = {32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                 32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        gaps = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("t5_junk_idle", {31'd0, busy}, 32'd0);
        send_frame(16'd8, 16'h0000, 8'h00, 1000);
        check_status("t5", 1'b1, 1'b0, 1'b0);
        gaps = 1'b0;

        // 6: reset in the middle of word 2, then a clean load
        send_frame(16'd8, 16'h0000, 8'h00, 15);
        check("t6_busy_mid", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("t6_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(16'd8, 16'h0000, 8'h00, 1000);
        check_status("t6", 1'b1, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("writes_left", exp_wr.size(), 32'd0);
        check("starts_left", exp_pc.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
